// File: rtl/bank_ticket_pkg.sv
// Shared encodings for the bank ticket queue: service types and the
// announce FSM state type. FIFO entries are declared in ticket_queue_ctrl
// because their field widths follow that module's parameters.
package bank_ticket_pkg;

    // Service-type encodings presented on ticket_service / call_service
    localparam logic [1:0] SVC_A = 2'd0;
    localparam logic [1:0] SVC_B = 2'd1;
    localparam logic [1:0] SVC_C = 2'd2;
    localparam logic [1:0] SVC_D = 2'd3;

    typedef enum logic {
        ANN_IDLE = 1'b0,
        ANN_HOLD = 1'b1
    } ann_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting officer at
// or after ptr, wrapping modulo NUM_OFFICERS.
module rr_arbiter #(
    parameter int NUM_OFFICERS = 4
) (
    input  logic [NUM_OFFICERS-1:0]         req,
    input  logic [$clog2(NUM_OFFICERS)-1:0] ptr,
    output logic [NUM_OFFICERS-1:0]         grant,
    output logic [$clog2(NUM_OFFICERS)-1:0] grant_idx,
    output logic                            grant_valid
);

    localparam int IDX_W = $clog2(NUM_OFFICERS);

    int j;

    // Scan from ptr upward and lock onto the first set request
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        for (int k = 0; k < NUM_OFFICERS; k++) begin
            j = (int'(ptr) + k) % NUM_OFFICERS;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ticket_queue_ctrl.sv
// Multi-officer ticket queue controller. Issues sequential tickets into a
// FIFO, dispatches the oldest ticket to calling officers round-robin, and
// holds each announcement for ANNOUNCE_CYCLES cycles.
// Optional feature: define STATS_EN to add per-officer served counters
// (served_count port, STAT_W parameter).
module ticket_queue_ctrl
    import bank_ticket_pkg::*;
#(
    parameter int TICKET_W        = 7,
    parameter int DEPTH           = 8,
    parameter int NUM_OFFICERS    = 4,
    parameter int SVC_W           = 2,
    parameter int ANNOUNCE_CYCLES = 4
`ifdef STATS_EN
    ,
    parameter int STAT_W          = 8
`endif
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ticket_req,
    input  logic [SVC_W-1:0]                ticket_service,
    input  logic [NUM_OFFICERS-1:0]         officer_call,
    output logic                            ticket_issued,
    output logic [TICKET_W-1:0]             issued_number,
    output logic                            req_reject,
    output logic                            queue_full,
    output logic                            queue_empty,
    output logic [$clog2(DEPTH+1)-1:0]      waiting_count,
    output logic                            call_valid,
    output logic [TICKET_W-1:0]             call_ticket,
    output logic [$clog2(NUM_OFFICERS)-1:0] call_officer,
    output logic [SVC_W-1:0]                call_service,
`ifdef STATS_EN
    output logic [NUM_OFFICERS*STAT_W-1:0]  served_count,
`endif
    output logic                            announce_busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(NUM_OFFICERS);
    localparam int TMR_W = $clog2(ANNOUNCE_CYCLES + 1);

    typedef struct packed {
        logic [TICKET_W-1:0] ticket;
        logic [SVC_W-1:0]    service;
    } entry_t;

    entry_t                  mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [TICKET_W-1:0]     next_ticket;

    logic                    req_prev;
    logic [NUM_OFFICERS-1:0] call_prev;
    logic [NUM_OFFICERS-1:0] pending;
    logic [OFF_W-1:0]        rr_ptr;

    ann_state_t              state;
    ann_state_t              state_nx;
    logic [TMR_W-1:0]        timer;
    logic [TMR_W-1:0]        timer_nx;

    logic                    req_edge;
    logic [NUM_OFFICERS-1:0] call_edge;
    logic [NUM_OFFICERS-1:0] grant_oh;
    logic [OFF_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    grant;
    logic                    full;
    logic                    push;
    logic                    reject;

    assign req_edge  = ticket_req & ~req_prev;
    assign call_edge = officer_call & ~call_prev;
    assign full      = (count == CNT_W'(DEPTH));

    // A pop in the same cycle frees the slot, so a request while full is still taken
    assign push   = req_edge & (~full | grant);
    assign reject = req_edge & full & ~grant;

    assign queue_full    = full;
    assign queue_empty   = (count == '0);
    assign waiting_count = count;

    rr_arbiter #(
        .NUM_OFFICERS (NUM_OFFICERS)
    ) u_arb (
        .req         (pending),
        .ptr         (rr_ptr),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_any)
    );

    // Announce FSM: grant only when idle with a ticket already stored, then hold
    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        grant         = 1'b0;
        announce_busy = 1'b0;
        case (state)
            ANN_IDLE: begin
                if (grant_any && (count != '0)) begin
                    grant    = 1'b1;
                    state_nx = ANN_HOLD;
                    timer_nx = TMR_W'(ANNOUNCE_CYCLES - 1);
                end
            end
            ANN_HOLD: begin
                announce_busy = 1'b1;
                if (timer == '0) begin
                    state_nx = ANN_IDLE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: state_nx = ANN_IDLE;
        endcase
    end

    // FSM state and hold timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ANN_IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // Button edge detection and pending-call latching
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_prev  <= 1'b0;
            call_prev <= '0;
            pending   <= '0;
            rr_ptr    <= '0;
        end else begin
            req_prev  <= ticket_req;
            call_prev <= officer_call;
            pending   <= (pending | call_edge) & ~(grant ? grant_oh : '0);
            if (grant) begin
                rr_ptr <= (grant_idx == OFF_W'(NUM_OFFICERS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and ticket numbering; 0 is skipped on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            next_ticket <= TICKET_W'(1);
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                next_ticket <= (next_ticket == '1) ? TICKET_W'(1) : next_ticket + 1'b1;
            end
            if (grant) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, grant})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; contents are meaningless once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ticket: next_ticket, service: ticket_service};
        end
    end

    // Registered issue and call outputs, one cycle after the accepting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ticket_issued <= 1'b0;
            req_reject    <= 1'b0;
            issued_number <= '0;
            call_valid    <= 1'b0;
            call_ticket   <= '0;
            call_service  <= '0;
            call_officer  <= '0;
        end else begin
            ticket_issued <= push;
            req_reject    <= reject;
            call_valid    <= grant;
            if (push) begin
                issued_number <= next_ticket;
            end
            if (grant) begin
                call_ticket  <= mem[rd_ptr].ticket;
                call_service <= mem[rd_ptr].service;
                call_officer <= grant_idx;
            end
        end
    end

`ifdef STATS_EN
    logic [STAT_W-1:0] served [NUM_OFFICERS];

    // Saturating per-officer served counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OFFICERS; i++) begin
                served[i] <= '0;
            end
        end else if (grant && (served[grant_idx] != '1)) begin
            served[grant_idx] <= served[grant_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_OFFICERS; g++) begin : g_stats
        assign served_count[g*STAT_W +: STAT_W] = served[g];
    end
`endif

endmodule

// File: tb/tb_ticket_queue_ctrl.sv
// Directed testbench for ticket_queue_ctrl with a scoreboard of expected
// issued numbers and expected call dispatches. STATS_EN adds served_count checks.
module tb_ticket_queue_ctrl;
    import bank_ticket_pkg::*;

    localparam int TW    = 7;
    localparam int DEPTH = 8;
    localparam int NOFF  = 4;
    localparam int SW    = 2;
    localparam int ANN   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            ticket_req;
    logic [SW-1:0]   ticket_service;
    logic [NOFF-1:0] officer_call;
    logic            ticket_issued;
    logic [TW-1:0]   issued_number;
    logic            req_reject;
    logic            queue_full;
    logic            queue_empty;
    logic [3:0]      waiting_count;
    logic            call_valid;
    logic [TW-1:0]   call_ticket;
    logic [1:0]      call_officer;
    logic [SW-1:0]   call_service;
    logic            announce_busy;

    logic            t3_req;
    logic [SW-1:0]   t3_service;
    logic [NOFF-1:0] t3_call;
    logic            t3_issued;
    logic [2:0]      t3_number;
    logic            t3_reject;
    logic            t3_full;
    logic            t3_empty;
    logic [3:0]      t3_count;
    logic            t3_cvalid;
    logic [2:0]      t3_cticket;
    logic [1:0]      t3_cofficer;
    logic [SW-1:0]   t3_cservice;
    logic            t3_busy;
`ifdef STATS_EN
    logic [NOFF*8-1:0] served_count;
    logic [NOFF*8-1:0] t3_served;
`endif

    ticket_queue_ctrl #(
        .TICKET_W(TW), .DEPTH(DEPTH), .NUM_OFFICERS(NOFF), .SVC_W(SW), .ANNOUNCE_CYCLES(ANN)
    ) dut (
        .clk(clk), .reset(reset), .ticket_req(ticket_req), .ticket_service(ticket_service),
        .officer_call(officer_call), .ticket_issued(ticket_issued), .issued_number(issued_number),
        .req_reject(req_reject), .queue_full(queue_full), .queue_empty(queue_empty),
        .waiting_count(waiting_count), .call_valid(call_valid), .call_ticket(call_ticket),
        .call_officer(call_officer), .call_service(call_service),
`ifdef STATS_EN
        .served_count(served_count),
`endif
        .announce_busy(announce_busy)
    );

    ticket_queue_ctrl #(
        .TICKET_W(3), .DEPTH(DEPTH), .NUM_OFFICERS(NOFF), .SVC_W(SW), .ANNOUNCE_CYCLES(ANN)
    ) dut3 (
        .clk(clk), .reset(reset), .ticket_req(t3_req), .ticket_service(t3_service),
        .officer_call(t3_call), .ticket_issued(t3_issued), .issued_number(t3_number),
        .req_reject(t3_reject), .queue_full(t3_full), .queue_empty(t3_empty),
        .waiting_count(t3_count), .call_valid(t3_cvalid), .call_ticket(t3_cticket),
        .call_officer(t3_cofficer), .call_service(t3_cservice),
`ifdef STATS_EN
        .served_count(t3_served),
`endif
        .announce_busy(t3_busy)
    );

    typedef struct packed {
        logic [TW-1:0] t;
        logic [SW-1:0] s;
        logic [1:0]    o;
    } call_t;

    call_t         mfifo[$];
    call_t         exp_call[$];
    logic [TW-1:0] exp_iss[$];
    int            rej_pending;
    logic [TW-1:0] m_next;
    int            n_assert;
    int            n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mfifo.delete();
        exp_call.delete();
        exp_iss.delete();
        rej_pending = 0;
        m_next      = 7'd1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ticket_req   = 1'b0;
        officer_call = '0;
        repeat (2) tick();
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    // Record a ticket the DUT should accept, in FIFO order
    task automatic model_push(input logic [SW-1:0] svc);
        mfifo.push_back('{t: m_next, s: svc, o: 2'd0});
        exp_iss.push_back(m_next);
        m_next = (m_next == 7'h7f) ? 7'd1 : m_next + 7'd1;
    endtask

    // Record that the oldest ticket goes to officer off
    task automatic expect_grant(input logic [1:0] off);
        call_t c;
        c   = mfifo.pop_front();
        c.o = off;
        exp_call.push_back(c);
    endtask

    task automatic press_req(input logic [SW-1:0] svc);
        bit acc;
        acc = (mfifo.size() < DEPTH);
        if (acc) model_push(svc);
        else rej_pending++;
        ticket_service = svc;
        ticket_req     = 1'b1;
        tick();
        chk("issue_pulse", ticket_issued, acc);
        chk("reject_pulse", req_reject, !acc);
        ticket_req = 1'b0;
        tick();
    endtask

    // Scoreboard side: compare every DUT event against the queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (ticket_issued) begin
                chk("issue_expected", exp_iss.size() != 0, 1);
                if (exp_iss.size() != 0) chk("issued_number", issued_number, exp_iss.pop_front());
            end
            if (req_reject) begin
                chk("reject_expected", rej_pending > 0, 1);
                if (rej_pending > 0) rej_pending--;
            end
            if (call_valid) begin
                chk("call_expected", exp_call.size() != 0, 1);
                if (exp_call.size() != 0)
                    chk("call_entry", {call_ticket, call_service, call_officer}, exp_call.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        ticket_req     = 1'b0;
        ticket_service = '0;
        officer_call   = '0;
        t3_req         = 1'b0;
        t3_service     = '0;
        t3_call        = '0;
        model_clear();

        // Reset state
        do_reset();
        chk("rst_issued", ticket_issued, 0);
        chk("rst_number", issued_number, 0);
        chk("rst_reject", req_reject, 0);
        chk("rst_full", queue_full, 0);
        chk("rst_empty", queue_empty, 1);
        chk("rst_count", waiting_count, 0);
        chk("rst_cvalid", call_valid, 0);
        chk("rst_cticket", call_ticket, 0);
        chk("rst_busy", announce_busy, 0);

        // Three requests with different services
        press_req(SVC_A);
        press_req(SVC_B);
        press_req(SVC_C);
        chk("t1_number", issued_number, 3);
        chk("t1_count", waiting_count, 3);
        chk("t1_empty", queue_empty, 0);

        // Two officers call together; round-robin order and announce hold
        do_reset();
        press_req(SVC_B);
        press_req(SVC_D);
        expect_grant(2'd0);
        expect_grant(2'd2);
        officer_call = 4'b0101;
        tick();
        officer_call = '0;
        tick();
        chk("t2_cvalid0", call_valid, 1);
        chk("t2_officer0", call_officer, 0);
        chk("t2_ticket0", call_ticket, 1);
        chk("t2_busy0", announce_busy, 1);
        chk("t2_count0", waiting_count, 1);
        repeat (ANN - 1) begin
            tick();
            chk("t2_hold_busy", announce_busy, 1);
            chk("t2_hold_nocall", call_valid, 0);
        end
        tick();
        chk("t2_idle_busy", announce_busy, 0);
        chk("t2_idle_nocall", call_valid, 0);
        tick();
        chk("t2_cvalid1", call_valid, 1);
        chk("t2_officer1", call_officer, 2);
        chk("t2_ticket1", call_ticket, 2);
        chk("t2_service1", call_service, SVC_D);
        chk("t2_rr_ptr", dut.rr_ptr, 3);
        chk("t2_empty", queue_empty, 1);
        repeat (ANN + 1) tick();

        // Fill past DEPTH, then push while full in the same cycle as a grant
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) press_req(SW'(i % 4));
        chk("t3_full", queue_full, 1);
        chk("t3_count_full", waiting_count, DEPTH);
        chk("t3_last_number", issued_number, DEPTH);
        expect_grant(2'd1);
        officer_call = 4'b0010;
        tick();
        officer_call   = '0;
        ticket_service = SVC_D;
        ticket_req     = 1'b1;
        model_push(SVC_D);
        tick();
        chk("t3_push_pop_issue", ticket_issued, 1);
        chk("t3_push_pop_noreject", req_reject, 0);
        chk("t3_push_pop_call", call_valid, 1);
        chk("t3_push_pop_count", waiting_count, DEPTH);
        chk("t3_push_pop_full", queue_full, 1);
        ticket_req = 1'b0;
        tick();
        chk("t3_push_pop_number", issued_number, DEPTH + 1);

        // Call with empty FIFO waits; grant one cycle after the later push
        do_reset();
        officer_call = 4'b0001;
        tick();
        officer_call = '0;
        repeat (3) begin
            tick();
            chk("t4_no_call_empty", call_valid, 0);
            chk("t4_no_busy_empty", announce_busy, 0);
        end
        model_push(SVC_C);
        ticket_service = SVC_C;
        ticket_req     = 1'b1;
        tick();
        chk("t4_issue", ticket_issued, 1);
        chk("t4_no_call_yet", call_valid, 0);
        chk("t4_count", waiting_count, 1);
        expect_grant(2'd0);
        ticket_req = 1'b0;
        tick();
        chk("t4_call", call_valid, 1);
        chk("t4_call_ticket", call_ticket, 1);
        chk("t4_call_service", call_service, SVC_C);
        chk("t4_count_after", waiting_count, 0);
        repeat (ANN + 1) tick();

        // Narrow ticket width: numbers wrap 7 -> 1, never 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            t3_req = 1'b1;
            tick();
            chk("t5_issue", t3_issued, 1);
            chk("t5_number", t3_number, (i % 7) + 1);
            t3_req = 1'b0;
            tick();
        end
        chk("t5_count", t3_count, 8);

        // Asynchronous reset during the announce hold
        do_reset();
        press_req(SVC_A);
        press_req(SVC_B);
        press_req(SVC_C);
        expect_grant(2'd0);
        officer_call = 4'b0001;
        tick();
        officer_call = '0;
        tick();
        chk("t6_call", call_valid, 1);
        tick();
        chk("t6_busy_before", announce_busy, 1);
        chk("t6_count_before", waiting_count, 2);
`ifdef STATS_EN
        chk("t6_served_before", served_count[7:0], 1);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("t6_busy_reset", announce_busy, 0);
        chk("t6_empty_reset", queue_empty, 1);
        chk("t6_count_reset", waiting_count, 0);
        chk("t6_cticket_reset", call_ticket, 0);
        chk("t6_number_reset", issued_number, 0);
`ifdef STATS_EN
        chk("t6_served_reset", served_count, 0);
`endif
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        press_req(SVC_A);
        chk("t6_next_ticket", issued_number, 1);
        tick();

        chk("issue_queue_drained", exp_iss.size(), 0);
        chk("call_queue_drained", exp_call.size(), 0);
        chk("reject_drained", rej_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
